// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter ownership of the memory port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DACC = 2'd1,
        ST_IACC = 2'd2
    } arb_state_t;

    // Default ack watchdog length in cycles (legal range 2..255)
    localparam int TIMEOUT_DEFAULT = 16;

    // Watchdog counter width
    localparam int WDOG_W = 8;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_wait_timer.sv
// Saturating wait counter: cleared on demand, counts enabled cycles,
// flags when the count has reached the supplied limit.
module mem_wait_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority; counting saturates at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt >= i_limit);

endmodule : mem_wait_timer

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data
// access. Data has fixed priority; each access is a req/ack handshake
// guarded by a watchdog. A completed access spends one cycle in its
// access state with o_mem_req low (the valid-pulse cycle) before IDLE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_flush_if,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_valid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_if,
    output logic              o_stall_mem,
    output logic              o_timeout
);

    localparam logic [WDOG_W-1:0] LP_WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    arb_state_t r_state;
    logic       r_drop;

    logic w_grant;
    logic w_timer_en;
    logic w_expired;
    logic w_drop;

    assign w_grant    = (r_state == ST_IDLE) &&
                        (i_d_req || (i_if_req && !i_flush_if));
    assign w_timer_en = o_mem_req && !i_mem_ack;
    // A flush in the ack/abort cycle itself also suppresses the fetch result
    assign w_drop     = r_drop || i_flush_if;

    assign o_stall_if  = i_if_req && !o_if_valid;
    assign o_stall_mem = i_d_req && !o_d_valid;

    mem_wait_timer #(
        .CNT_W (WDOG_W)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_grant),
        .i_enable  (w_timer_en),
        .i_limit   (LP_WDOG_LIMIT),
        .o_expired (w_expired)
    );

    // Grant, hold request until ack/abort, then pulse the owner's valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_drop      <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_d_valid   <= 1'b0;
            o_d_rdata   <= '0;
            o_timeout   <= 1'b0;
        end else begin
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;
            o_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (i_d_req) begin
                        r_state     <= ST_DACC;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_d_we;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                    end else if (i_if_req && !i_flush_if) begin
                        r_state    <= ST_IACC;
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= i_if_addr;
                    end
                end
                ST_DACC: begin
                    if (o_mem_req) begin
                        if (i_mem_ack) begin
                            o_mem_req <= 1'b0;
                            o_d_valid <= 1'b1;
                            o_d_rdata <= o_mem_we ? '0 : i_mem_rdata;
                        end else if (w_expired) begin
                            o_mem_req <= 1'b0;
                            o_timeout <= 1'b1;
                            o_d_valid <= 1'b1;
                            o_d_rdata <= '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IACC: begin
                    if (o_mem_req) begin
                        if (i_flush_if) begin
                            r_drop <= 1'b1;
                        end
                        if (i_mem_ack) begin
                            o_mem_req <= 1'b0;
                            if (!w_drop) begin
                                o_if_valid <= 1'b1;
                                o_if_rdata <= i_mem_rdata;
                            end
                        end else if (w_expired) begin
                            o_mem_req <= 1'b0;
                            o_timeout <= 1'b1;
                            if (!w_drop) begin
                                o_if_valid <= 1'b1;
                                o_if_rdata <= '0;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_drop  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the pipelined ARM core between two requesters: instruction fetch (IF stage, read-only) and data access (MEM stage, LDR/STR).
- Data access has fixed priority over fetch.
- Each access is a req/ack transaction, with a timeout watchdog on the ack.
- Stall levels go to the hazard unit, and IF-flush requests from branch resolution are honoured.
- Sits between the IF/MEM stages and the memory model/bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, cycles to wait for i_mem_ack before aborting; legal range 2..255

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_if_req  input  1  fetch request level, held until o_if_valid
i_if_addr  input  ADDR_W  fetch address (PC)
i_flush_if  input  1  discard current/pending fetch (branch taken)
o_if_valid  output  1  one-cycle pulse: o_if_rdata valid
o_if_rdata  output  DATA_W  fetched instruction
i_d_req  input  1  data request level, held until o_d_valid
i_d_we  input  1  1 = store, 0 = load
i_d_addr  input  ADDR_W  data address
i_d_wdata  input  DATA_W  store data
o_d_valid  output  1  one-cycle pulse: data access complete
o_d_rdata  output  DATA_W  load data
o_mem_req  output  1  memory request, held until ack or abort
o_mem_we  output  1  write enable to memory
o_mem_addr  output  ADDR_W  memory address
o_mem_wdata  output  DATA_W  memory write data
i_mem_ack  input  1  one-cycle ack; i_mem_rdata valid in the same cycle
i_mem_rdata  input  DATA_W  memory read data
o_stall_if  output  1  combinational: i_if_req && !o_if_valid
o_stall_mem  output  1  combinational: i_d_req && !o_d_valid
o_timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Clocking: one clock, i_clk. Reset is asynchronous, active-low on i_rst_n.
- Reset values:
  - State returns to IDLE.
  - All registered outputs are 0: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_if_valid, o_if_rdata, o_d_valid, o_d_rdata, o_timeout.
  - Drop flag and watchdog counter are cleared.
- Reset mid-transaction: the transaction is abandoned with no valid pulse. A late i_mem_ack after reset release is ignored in IDLE.
- States: IDLE, DACC, IACC. All memory-side outputs are registered.
- IDLE:
  - If i_d_req: latch addr/we/wdata, assert o_mem_req next cycle, go to DACC.
  - Else if i_if_req && !i_flush_if: latch i_if_addr, set o_mem_we = 0, assert o_mem_req, go to IACC.
  - Else stay in IDLE.
  - Both requests in the same cycle: data wins; fetch waits.
- DACC / IACC: o_mem_req held with stable address/data until i_mem_ack.
- Ack cycle:
  - Deassert o_mem_req.
  - Next cycle: pulse o_d_valid or o_if_valid with the registered rdata, then return to IDLE.
  - o_d_rdata is 0 for stores.
  - Minimum latency request to valid: 2 cycles (ack on the first req cycle).
  - One IDLE bubble between back-to-back transactions.
- Requester obligation: drop the request in the cycle after the valid pulse. If the request is still high in IDLE, it is a new request.
- Flush:
  - i_flush_if in IACC sets a drop flag. On ack, no o_if_valid pulse; return to IDLE.
  - i_flush_if in IDLE blocks the fetch grant that cycle only.
  - Flush has no effect on DACC.
- Watchdog:
  - 8-bit counter, cleared on entry to DACC/IACC, increments each cycle o_mem_req is high without ack.
  - When it reaches TIMEOUT-1 without ack: deassert o_mem_req, pulse o_timeout, pulse the owning requester's valid with rdata = 0 (IACC with drop flag set: no valid pulse), return to IDLE.
- Ack while o_mem_req is low (spurious) is ignored.
- The drop flag is cleared on every return to IDLE.

Decomposition:
- Shared package: state enum (IDLE/DACC/IACC) and a TIMEOUT_DEFAULT constant.
- One sub-module, mem_wait_timer: clear, enable, limit input, expired output. It is reused by future cache-miss sequencing.
- All other logic stays in the top module.

Test Plan:
- Fetch only: i_if_req, addr 0x0000_0010, ack on 1st req cycle with rdata 0xE3A0_1005 -> o_if_valid 2 cycles after request with 0xE3A0_1005; o_stall_if high until the valid cycle.
- Simultaneous i_d_req (load 0x100) and i_if_req (0x14) -> o_mem_addr = 0x100 first; fetch granted after o_d_valid plus 1 bubble; o_stall_if high throughout.
- Store 0xDEADBEEF to 0x200, ack delayed 3 cycles -> o_mem_we = 1 with addr/wdata stable all 4 req cycles; o_d_valid one pulse with o_d_rdata = 0.
- Fetch in IACC, i_flush_if pulsed before ack -> no o_if_valid; IDLE afterwards; new fetch from the new PC is served normally.
- No ack, TIMEOUT = 4, data load -> o_mem_req drops after 4 cycles; o_timeout and o_d_valid pulse together with o_d_rdata = 0.
- i_rst_n low during DACC, late ack after release -> outputs 0, no valid pulse, state IDLE.
